// File: rtl/mic_receiver.sv
`default_nettype none
// ============================================================================
// Module      : mic_receiver
// Description : I2S master-mode receiver for the microphone/ADC codec.
//               Generates audio_sysclk / audio_bck / audio_ws from clk, with
//               the same timing as the speaker DAC path. Deserialises 16-bit
//               left/right samples and hands each stereo pair to the
//               consumer over a valid/ready handshake.
//               bck and ws are plain register outputs and never clock logic.
// Ports       : clk, rst_n        - system clock (40 MHz), async active-low reset
//               audio_sysclk      - codec master clock (= clk)
//               audio_bck         - I2S bit clock (clk / 2^BCK_DIV_LOG2)
//               audio_ws          - I2S word select (0 = left, 1 = right)
//               audio_din         - serial data from the codec (asynchronous)
//               out_left/right    - sample pair, two's complement
//               out_valid/ready   - pair handshake
//               overrun           - sticky: a pair was overwritten unaccepted
//               overrun_clr       - one-cycle clear of overrun
//               peak_level/valid  - only with MIC_PEAK_EN: max |left| over
//                                   256 committed pairs, with 1-clk strobe
// Options     : `define MIC_PEAK_EN adds the peak meter ports and logic.
// Revision    : 1.0 - initial release
// ============================================================================
module mic_receiver #(
    parameter int DATA_W_LOG2  = 4,
    parameter int BCK_DIV_LOG2 = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          audio_sysclk,
    output logic                          audio_bck,
    output logic                          audio_ws,
    input  logic                          audio_din,
    output logic [(2**DATA_W_LOG2)-1:0]   out_left,
    output logic [(2**DATA_W_LOG2)-1:0]   out_right,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun,
`ifdef MIC_PEAK_EN
    output logic [(2**DATA_W_LOG2)-1:0]   peak_level,
    output logic                          peak_valid,
`endif
    input  logic                          overrun_clr
);

    localparam int c_DATA_W = 2 ** DATA_W_LOG2;
    localparam int c_CNT_W  = BCK_DIV_LOG2 + DATA_W_LOG2 + 1;
    // Sample two clk after the bck rise to absorb the synchroniser delay.
    localparam int c_STROBE_PHASE = (1 << (BCK_DIV_LOG2 - 1)) + 1;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_sync1;
    logic                r_din_s;
    logic [c_DATA_W-1:0] r_sr;
    logic [c_DATA_W-1:0] r_left_hold;
    logic [c_DATA_W-1:0] r_out_left;
    logic [c_DATA_W-1:0] r_out_right;
    logic                r_out_valid;
    logic                r_overrun;
    state_t              r_state;
    state_t              w_state_next;

    logic                w_strobe;
    logic                w_slot0;
    logic                w_left_cap;
    logic                w_right_cap;
    logic                w_commit;
    logic [c_DATA_W-1:0] w_word;

    // ------------------------------------------------------------------
    // Clock generation: everything is decoded from one free-running count
    // so ws always changes on a bck falling edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign audio_sysclk = clk;
    assign audio_bck    = r_cnt[BCK_DIV_LOG2-1];
    assign audio_ws     = r_cnt[c_CNT_W-1];

    // ------------------------------------------------------------------
    // Input synchroniser and serial-to-parallel shift register
    // ------------------------------------------------------------------
    assign w_strobe    = (r_cnt[BCK_DIV_LOG2-1:0] == c_STROBE_PHASE[BCK_DIV_LOG2-1:0]);
    assign w_slot0     = (r_cnt[c_CNT_W-2:BCK_DIV_LOG2] == '0);
    assign w_word      = {r_sr[c_DATA_W-2:0], r_din_s};
    // One-bit I2S delay: the slot-0 strobe completes the channel that just
    // ended, so ws high here means the left word has just finished.
    assign w_left_cap  = w_strobe & w_slot0 &  r_cnt[c_CNT_W-1];
    assign w_right_cap = w_strobe & w_slot0 & ~r_cnt[c_CNT_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_din_s     <= 1'b0;
            r_sr        <= '0;
            r_left_hold <= '0;
        end else begin
            r_sync1 <= audio_din;
            r_din_s <= r_sync1;
            if (w_strobe) begin
                r_sr <= w_word;
            end
            if (w_left_cap) begin
                r_left_hold <= w_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: skip the partial first half-frame, then pair each left
    // word with the right word that follows it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            ST_START: begin
                if (w_right_cap) begin
                    w_state_next = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (w_left_cap) begin
                    w_state_next = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                if (w_right_cap) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_LEFT;
                end
            end
            default: begin
                w_state_next = ST_START;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and handshake. A new pair always replaces the old
    // one; if the old one was still pending the loss is flagged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_left  <= '0;
            r_out_right <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_out_left  <= r_left_hold;
                r_out_right <= w_word;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Set has priority over clear.
            if (w_commit && r_out_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_left  = r_out_left;
    assign out_right = r_out_right;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

`ifdef MIC_PEAK_EN
    // ------------------------------------------------------------------
    // Peak meter on the left channel over windows of 256 pairs.
    // ------------------------------------------------------------------
    localparam logic [7:0] c_PEAK_LAST = 8'hFF;

    logic [c_DATA_W-1:0] r_peak_max;
    logic [7:0]          r_peak_cnt;
    logic [c_DATA_W-1:0] r_peak_level;
    logic                r_peak_valid;
    logic [c_DATA_W-1:0] w_mag;
    logic [c_DATA_W-1:0] w_peak_sel;

    // |x| with the most negative value saturated to the most positive.
    always_comb begin
        w_mag = r_left_hold;
        if (r_left_hold[c_DATA_W-1]) begin
            if (r_left_hold == {1'b1, {(c_DATA_W-1){1'b0}}}) begin
                w_mag = {1'b0, {(c_DATA_W-1){1'b1}}};
            end else begin
                w_mag = ~r_left_hold + 1'b1;
            end
        end
    end

    assign w_peak_sel = (w_mag > r_peak_max) ? w_mag : r_peak_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_max   <= '0;
            r_peak_cnt   <= '0;
            r_peak_level <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_commit) begin
                if (r_peak_cnt == c_PEAK_LAST) begin
                    r_peak_level <= w_peak_sel;
                    r_peak_valid <= 1'b1;
                    r_peak_max   <= '0;
                    r_peak_cnt   <= '0;
                end else begin
                    r_peak_max   <= w_peak_sel;
                    r_peak_cnt   <= r_peak_cnt + 8'd1;
                end
            end
        end
    end

    assign peak_level = r_peak_level;
    assign peak_valid = r_peak_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mic_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_mic_receiver
// Description : Directed self-checking bench for mic_receiver. A behavioural
//               I2S codec drives audio_din from the observed bck/ws; the main
//               sequence tracks time t in clk cycles since reset release
//               (cnt == t mod 256) and checks hand-derived expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mic_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        audio_sysclk;
    logic        audio_bck;
    logic        audio_ws;
    logic        audio_din = 1'b0;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overrun;
    logic        overrun_clr = 1'b0;
`ifdef MIC_PEAK_EN
    logic [15:0] peak_level;
    logic        peak_valid;
`endif

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    logic [15:0] left_pat  = 16'hA5C3;
    logic [15:0] right_pat = 16'h3C5A;

    always #5 clk = ~clk;

    mic_receiver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_sysclk (audio_sysclk),
        .audio_bck    (audio_bck),
        .audio_ws     (audio_ws),
        .audio_din    (audio_din),
        .out_left     (out_left),
        .out_right    (out_right),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
`ifdef MIC_PEAK_EN
        .peak_level   (peak_level),
        .peak_valid   (peak_valid),
`endif
        .overrun_clr  (overrun_clr)
    );

    // I2S codec: new bit on each bck fall; at a ws edge emit the LSB of the
    // finished word, then start the next channel MSB first.
    initial begin
        logic [15:0] cur;
        int          idx;
        logic        prev_ws;
        logic        prev_bck;
        cur = 16'h0; idx = 15; prev_ws = 1'b0; prev_bck = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cur       = left_pat;
                idx       = 15;
                prev_ws   = 1'b0;
                prev_bck  = 1'b0;
                audio_din = 1'b0;
            end else begin
                if (audio_ws != prev_ws) begin
                    audio_din = cur[0];
                    cur       = audio_ws ? right_pat : left_pat;
                    idx       = 15;
                end else if (prev_bck && !audio_bck) begin
                    audio_din = cur[idx];
                    if (idx > 0) idx--;
                end
                prev_ws  = audio_ws;
                prev_bck = audio_bck;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    initial begin
        logic exp_v;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_left", out_left, 0);
        chk("rst_right", out_right, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bck", audio_bck, 0);
        chk("rst_ws", audio_ws, 0);
        chk("sysclk_low", audio_sysclk, 0);
        @(posedge clk);
        #1;
        chk("sysclk_high", audio_sysclk, 1);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;

        // ---------------- clocks and steady-state pairs ----------------
        while (t < 700) begin
            tick();
            chk("bck_wave", audio_bck, ((t % 8) >= 4) ? 1 : 0);
            chk("ws_wave", audio_ws, ((t % 256) >= 128) ? 1 : 0);
            exp_v = (t >= 262) && ((t % 256) == 6);
            chk("valid_pulse", out_valid, exp_v);
            if (exp_v) begin
                chk("pair_left", out_left, 16'hA5C3);
                chk("pair_right", out_right, 16'h3C5A);
            end
        end

        // ---------------- backpressure / overrun ----------------
        left_pat  = 16'h1234;
        right_pat = 16'h5678;
        run_to(780);
        chk("accepted_idle", out_valid, 0);
        out_ready = 1'b0;
        run_to(1000);
        left_pat  = 16'h9ABC;
        right_pat = 16'hDEF0;
        run_to(1030);
        chk("bp1_valid", out_valid, 1);
        chk("bp1_left", out_left, 16'h1234);
        chk("bp1_right", out_right, 16'h5678);
        chk("bp1_overrun", overrun, 0);
        run_to(1286);
        chk("bp2_valid", out_valid, 1);
        chk("bp2_left", out_left, 16'h9ABC);
        chk("bp2_right", out_right, 16'hDEF0);
        chk("bp2_overrun", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);
        chk("ovr_clr_valid", out_valid, 1);

        // clear coincides with a new overrun: set wins
        run_to(1541);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        chk("ovr_set_left", out_left, 16'h9ABC);
        out_ready = 1'b1;
        tick();
        chk("accept_clears", out_valid, 0);
        chk("ovr_sticky", overrun, 1);

        // ---------------- reset mid-frame ----------------
        left_pat  = 16'hBEEF;
        right_pat = 16'h0123;
        run_to(1722);   // cnt 186: slot 7 of the right half
        chk("pre_rst_ws", audio_ws, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_left", out_left, 0);
        chk("mid_rst_right", out_right, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_ws", audio_ws, 0);
        chk("mid_rst_bck", audio_bck, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (t < 261) begin
            tick();
            chk("no_early_valid", out_valid, 0);
        end
        tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_left", out_left, 16'hBEEF);
        chk("post_rst_right", out_right, 16'h0123);
        tick();
        chk("post_rst_pulse", out_valid, 0);

`ifdef MIC_PEAK_EN
        // ---------------- peak meter ----------------
        @(negedge clk);
        left_pat  = 16'h0100;
        right_pat = 16'h0055;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("peak_rst_level", peak_level, 0);
        chk("peak_rst_valid", peak_valid, 0);
        rst_n = 1'b1;
        t = 0;
        run_to(65180);
        chk("peak_no_early", peak_valid, 0);
        left_pat = 16'h8000;
        run_to(65541);
        chk("peak_before", peak_valid, 0);
        tick();
        chk("peak_pulse", peak_valid, 1);
        chk("peak_level", peak_level, 16'h7FFF);
        chk("peak_left", out_left, 16'h8000);
        tick();
        chk("peak_pulse_end", peak_valid, 0);
        chk("peak_level_hold", peak_level, 16'h7FFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
